edge_detect_multi: RTL and testbench
====================================

// Module: edge_detect_multi
// PURPOSE
//  Parametrised N-channel edge detector for async board inputs (buttons, straps, ext IRQ lines).
//  Per channel: synchroniser, debounce filter, selectable edge mode, and a single-cycle pulse.
//  Sticky pending flags feed one OR-reduced irq line to the core's interrupt controller.
// PARAMETERS
//  N_CH            4      number of independent channels (>=1)
//  SYNC_STAGES     2      synchroniser depth (>=2)
//  DEBOUNCE_CYCLES 16     consecutive stable synced cycles required to accept a new level (>=1)
//  ACTIVE_LOW      '0     [N_CH-1:0] per-channel polarity; bit=1 means raw 0 is "asserted"
// PORTS
//  clk        in   1        system clock
//  reset      in   1        asynchronous, active-high reset
//  signal     in   N_CH     raw async inputs
//  edge_mode  in   2*N_CH   per ch [2i+1:2i]: 00 off, 01 assert edge, 10 de-assert edge, 11 both
//  clr        in   N_CH     write-1-to-clear pending, per channel
//  level      out  N_CH     debounced level, normalised (1 = asserted)
//  pulse      out  N_CH     1-cycle strobe on a qualifying debounced edge
//  pending    out  N_CH     sticky event flags
//  irq        out  1        |pending
// BEHAVIOUR
//  Clock/reset: one clock; reset is asynchronous and active-high.
//  Reset values: sync chain = ACTIVE_LOW[i] (raw de-asserted level); level=0; pulse=0;
//   pending=0; irq=0; debounce counters=0. Reset mid-debounce discards the count.
//  Normalise: s[i] = sync_out[i] ^ ACTIVE_LOW[i]; all following logic uses s (1 = asserted).
//  Debounce, per channel, counter width $clog2(DEBOUNCE_CYCLES+1):
//   - s == level: cnt <= 0.
//   - s != level and cnt == DEBOUNCE_CYCLES-1: level <= s, cnt <= 0 (accept).
//   - s != level otherwise: cnt <= cnt+1. Any glitch back to level restarts from 0.
//  Latency: a raw change held stable is reflected in level and pulse exactly
//   SYNC_STAGES + DEBOUNCE_CYCLES rising clk edges after the first edge that samples it.
//  Pulse (registered): on the edge where level is accepted:
//   - 0->1 with mode[0]=1, or 1->0 with mode[1]=1: pulse=1 for exactly one cycle.
//   - mode 00: no pulse, no pending; level still tracks.
//   - mode is sampled on the accept edge only; a mode change never creates or clears events.
//  Pending: set by pulse on the same edge; cleared by clr[i]=1. Set and clr on the same edge
//   for one channel: set wins (pending stays 1). clr on a channel with pending=0: no effect.
//  irq: registered OR of pending, so it asserts one cycle after pending.
//  Channels are fully independent; simultaneous events on several channels all register.
//  Input asserted at reset release: treated as a real assert edge after the normal latency.
//  Back-to-back accepted edges are separated by >= DEBOUNCE_CYCLES cycles, so pulses never merge.
//  Counters saturate by construction (reset at accept); no wrap-around is reachable.
// TESTING (N_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=4, ACTIVE_LOW=4'b0010, modes 11/01/10/00)
//  1 Reset with signal=4'b0010, release, hold 20 cycles -> level=0, pulse=0, pending=0, irq=0.
//  2 ch0 raw 0->1 held -> level[0] and pulse[0] at edge 6, pulse 1 cycle wide, pending[0]=1,
//    irq=1 at edge 7; ch0 raw 1->0 -> second pulse 6 edges later.
//  3 ch0 raw high for 3 cycles then low (glitch) -> no level change, no pulse; then 4 stable
//    cycles after the sync delay -> accepted.
//  4 ch1 (active-low, mode 01) raw 1->0 -> pulse[1]; raw 0->1 -> level[1]=0, no pulse.
//    ch3 (mode 00) toggles -> level tracks, pulse[3] and pending[3] stay 0.
//  5 clr[0]=1 on the same edge as a new ch0 pulse -> pending[0] stays 1; clr[0] next -> 0, irq 0.
//  6 Assert reset mid-debounce (cnt=2) -> all outputs 0 immediately; after release the input
//    needs the full 6-edge latency again.

Source files
------------

// File: rtl/edge_detect_multi_if.sv
// ----------------------------------------------------------------------------
// edge_detect_multi_if
//   Bundles the channel-facing signals of edge_detect_multi.
//   master : the side that owns the raw inputs and configuration (board/core)
//   slave  : the edge detector itself
//
//   signal    [N_CH-1:0]    raw asynchronous inputs
//   edge_mode [2*N_CH-1:0]  per channel [2i+1:2i]: 00 off, 01 assert, 10 de-assert, 11 both
//   clr       [N_CH-1:0]    write-1-to-clear pending
//   level     [N_CH-1:0]    debounced, normalised level (1 = asserted)
//   pulse     [N_CH-1:0]    one-cycle strobe on a qualifying debounced edge
//   pending   [N_CH-1:0]    sticky event flags
//   irq                     OR of pending, registered
//
//   There is no valid/ready handshake here: inputs are level-sampled every
//   clock and outputs are registered and valid every cycle.
// ----------------------------------------------------------------------------
interface edge_detect_multi_if #(
   parameter int N_CH = 4
);
   logic [N_CH-1:0]   signal;
   logic [2*N_CH-1:0] edge_mode;
   logic [N_CH-1:0]   clr;
   logic [N_CH-1:0]   level;
   logic [N_CH-1:0]   pulse;
   logic [N_CH-1:0]   pending;
   logic              irq;

   modport master (
      output signal, edge_mode, clr,
      input  level, pulse, pending, irq
   );

   modport slave (
      input  signal, edge_mode, clr,
      output level, pulse, pending, irq
   );
endinterface

// File: rtl/edge_detect_multi.sv
// ----------------------------------------------------------------------------
// edge_detect_multi
//   N-channel edge detector for asynchronous board inputs. Each channel has a
//   synchroniser, a debounce filter, a selectable edge qualifier producing a
//   single-cycle pulse, and a sticky pending flag. All pending flags are
//   OR-reduced into one registered irq line.
//
//   Ports
//     clk    system clock
//     reset  asynchronous, active-high reset
//     bus    edge_detect_multi_if.slave (signal, edge_mode, clr in;
//            level, pulse, pending, irq out)
//
//   A raw change held stable shows up on level/pulse SYNC_STAGES +
//   DEBOUNCE_CYCLES rising edges after the first edge that samples it.
// ----------------------------------------------------------------------------
module edge_detect_multi #(
   parameter int              N_CH            = 4,
   parameter int              SYNC_STAGES     = 2,
   parameter int              DEBOUNCE_CYCLES = 16,
   parameter logic [N_CH-1:0] ACTIVE_LOW      = '0
) (
   input  logic                clk,
   input  logic                reset,
   edge_detect_multi_if.slave  bus
);

   localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q [N_CH];
   logic [CNT_W-1:0]       cnt_q  [N_CH];
   logic [N_CH-1:0]        level_q;
   logic [N_CH-1:0]        pulse_q;
   logic [N_CH-1:0]        pending_q;
   logic                   irq_q;

   // Normalised synchronised input, accept strobe and qualified event.
   logic [N_CH-1:0]        s;
   logic [N_CH-1:0]        accept;
   logic [N_CH-1:0]        fire;

   always_comb begin
      s      = '0;
      accept = '0;
      fire   = '0;
      for (int i = 0; i < N_CH; i++) begin
         s[i]      = sync_q[i][SYNC_STAGES-1] ^ ACTIVE_LOW[i];
         accept[i] = (s[i] != level_q[i]) && (cnt_q[i] == CNT_LAST);
         // s is the level being accepted: 1 means an assert edge, 0 a de-assert
         // edge. Mode is only looked at here, so changing it never makes or
         // drops an event by itself.
         fire[i]   = accept[i] && (s[i] ? bus.edge_mode[2*i] : bus.edge_mode[2*i+1]);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < N_CH; i++) begin
            // Chain starts at the raw de-asserted level so an input already
            // asserted at release is seen as a genuine assert edge.
            sync_q[i] <= {SYNC_STAGES{ACTIVE_LOW[i]}};
            cnt_q[i]  <= '0;
         end
         level_q   <= '0;
         pulse_q   <= '0;
         pending_q <= '0;
         irq_q     <= 1'b0;
      end else begin
         for (int i = 0; i < N_CH; i++) begin
            sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], bus.signal[i]};

            if (s[i] == level_q[i]) begin
               // Any return to the current level restarts the stability count.
               cnt_q[i] <= '0;
            end else if (accept[i]) begin
               level_q[i] <= s[i];
               cnt_q[i]   <= '0;
            end else begin
               cnt_q[i] <= cnt_q[i] + 1'b1;
            end
         end
         pulse_q   <= fire;
         // A new event beats a simultaneous clear.
         pending_q <= fire | (pending_q & ~bus.clr);
         irq_q     <= |pending_q;
      end
   end

   assign bus.level   = level_q;
   assign bus.pulse   = pulse_q;
   assign bus.pending = pending_q;
   assign bus.irq     = irq_q;

endmodule

// File: tb/tb_edge_detect_multi.sv
// ----------------------------------------------------------------------------
// tb_edge_detect_multi
//   Directed bench for edge_detect_multi with N_CH=4, SYNC_STAGES=2,
//   DEBOUNCE_CYCLES=4, ACTIVE_LOW=4'b0010, modes ch3..ch0 = 00/10/01/11.
//   Expected pulse vectors are queued when an input change is driven and
//   popped when the DUT strobes pulse.
// ----------------------------------------------------------------------------
module tb_edge_detect_multi;

   localparam int N_CH = 4;
   localparam int LAT  = 6;   // SYNC_STAGES + DEBOUNCE_CYCLES

   logic clk;
   logic reset;

   edge_detect_multi_if #(.N_CH(N_CH)) bus ();

   edge_detect_multi #(
      .N_CH            (N_CH),
      .SYNC_STAGES     (2),
      .DEBOUNCE_CYCLES (4),
      .ACTIVE_LOW      (4'b0010)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- scoreboard ----------------
   logic [N_CH-1:0] exp_q [$];
   int              n_checks = 0;
   int              n_pass   = 0;
   logic [N_CH-1:0] pulse_acc;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   // Advance one rising edge and sample 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_watch(input int n);
      pulse_acc = '0;
      for (int k = 0; k < n; k++) begin
         step();
         pulse_acc = pulse_acc | bus.pulse;
      end
   endtask

   // Wait (bounded) for a pulse, check its latency, value and width.
   task automatic wait_event(input string tag);
      int              lat;
      logic [N_CH-1:0] expv;
      lat = 0;
      do begin
         step();
         lat++;
      end while (bus.pulse == '0 && lat < 12);
      expv = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
      check({tag, " latency"}, lat, LAT);
      check({tag, " pulse"}, bus.pulse, expv);
      step();
      check({tag, " width"}, bus.pulse, 0);
   endtask

   task automatic clr_all();
      bus.clr = 4'hF;
      step();
      bus.clr = 4'h0;
      step();
      check("clr_all pending", bus.pending, 0);
      check("clr_all irq", bus.irq, 0);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      reset         = 1'b1;
      bus.signal    = 4'b0010;
      bus.edge_mode = 8'b00_10_01_11;
      bus.clr       = 4'h0;
      step();
      step();
      check("in reset level", bus.level, 0);
      check("in reset irq", bus.irq, 0);

      // 1: idle after reset
      reset = 1'b0;
      run_watch(20);
      check("idle level", bus.level, 0);
      check("idle pulse seen", pulse_acc, 0);
      check("idle pending", bus.pending, 0);
      check("idle irq", bus.irq, 0);

      // 2: ch0 rise and fall
      bus.signal[0] = 1'b1;
      exp_q.push_back(4'b0001);
      wait_event("ch0 rise");
      check("ch0 rise level", bus.level, 4'b0001);
      check("ch0 rise pending", bus.pending, 4'b0001);
      check("ch0 rise irq", bus.irq, 1);
      bus.signal[0] = 1'b0;
      exp_q.push_back(4'b0001);
      wait_event("ch0 fall");
      check("ch0 fall level", bus.level, 0);
      clr_all();

      // 3: glitch of 3 cycles is rejected, a stable level is accepted
      bus.signal[0] = 1'b1;
      step(); step(); step();
      bus.signal[0] = 1'b0;
      run_watch(10);
      check("glitch pulse seen", pulse_acc, 0);
      check("glitch level", bus.level, 0);
      check("glitch pending", bus.pending, 0);
      bus.signal[0] = 1'b1;
      exp_q.push_back(4'b0001);
      wait_event("stable rise");
      check("stable rise level", bus.level, 4'b0001);
      bus.signal[0] = 1'b0;
      exp_q.push_back(4'b0001);
      wait_event("stable fall");
      clr_all();

      // 4: active-low ch1 (assert-only), ch2 (de-assert-only), ch3 (off)
      bus.signal[1] = 1'b0;
      exp_q.push_back(4'b0010);
      wait_event("ch1 assert");
      check("ch1 assert level", bus.level, 4'b0010);
      bus.signal[1] = 1'b1;
      run_watch(8);
      check("ch1 deassert no pulse", pulse_acc, 0);
      check("ch1 deassert level", bus.level, 0);

      bus.signal[2] = 1'b1;
      run_watch(8);
      check("ch2 assert no pulse", pulse_acc, 0);
      check("ch2 assert level", bus.level, 4'b0100);
      bus.signal[2] = 1'b0;
      exp_q.push_back(4'b0100);
      wait_event("ch2 deassert");
      check("ch2 deassert level", bus.level, 0);

      bus.signal[3] = 1'b1;
      run_watch(8);
      check("ch3 on no pulse", pulse_acc, 0);
      check("ch3 on level", bus.level, 4'b1000);
      check("ch3 on pending", bus.pending[3], 0);
      bus.signal[3] = 1'b0;
      run_watch(8);
      check("ch3 off no pulse", pulse_acc, 0);
      check("ch3 off level", bus.level, 0);
      check("pending after ch1/ch2", bus.pending, 4'b0110);

      // simultaneous ch0 assert and ch1 assert
      bus.signal = bus.signal ^ 4'b0011;
      exp_q.push_back(4'b0011);
      wait_event("dual assert");
      check("dual level", bus.level, 4'b0011);
      check("dual pending", bus.pending, 4'b0111);
      bus.signal = bus.signal ^ 4'b0011;
      exp_q.push_back(4'b0001);
      wait_event("dual deassert");
      clr_all();

      // 5: clear on the same edge as a new event loses
      bus.signal[0] = 1'b1;
      exp_q.push_back(4'b0001);
      for (int k = 0; k < LAT - 1; k++) step();
      bus.clr = 4'b0001;
      step();
      check("set-vs-clr pulse", bus.pulse, exp_q.pop_front());
      check("set-vs-clr pending", bus.pending, 4'b0001);
      step();
      check("clr pending", bus.pending, 0);
      bus.clr = 4'b0000;
      step();
      check("clr irq", bus.irq, 0);

      // 6: reset in mid-debounce, full latency afterwards
      bus.signal[0] = 1'b0;
      exp_q.push_back(4'b0001);
      wait_event("pre-reset fall");
      check("pre-reset pending", bus.pending, 4'b0001);
      bus.signal[0] = 1'b1;
      step(); step(); step(); step();   // counter is at 2 here
      #2;
      reset = 1'b1;
      #1;
      check("async reset level", bus.level, 0);
      check("async reset pulse", bus.pulse, 0);
      check("async reset pending", bus.pending, 0);
      check("async reset irq", bus.irq, 0);
      step();
      step();
      reset = 1'b0;
      exp_q.push_back(4'b0001);
      wait_event("post-reset rise");
      check("post-reset level", bus.level, 4'b0001);
      check("queue drained", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
